// File: rtl/sweep_ctrl.sv
// sweep_ctrl: walks one picoMIPS core across a range of sample indices.
// Each sample holds core_handshake high for RUN_CYCLES, captures core_result,
// then drops handshake for GAP_CYCLES so the core returns to IDLE before the
// next index. Captured {result, index} pairs queue in a small FIFO.
// Optional feature: define SWEEP_ABORT_EN to add the abort input.
module sweep_ctrl #(
  parameter int unsigned RUN_CYCLES = 96,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] first_index,
  input  logic [7:0] count,
`ifdef SWEEP_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       core_handshake,
  output logic [7:0] core_index,
  input  logic [7:0] core_result,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [7:0] res_index,
  input  logic       res_ready
);

  localparam int unsigned CntMax   = (RUN_CYCLES > GAP_CYCLES) ? RUN_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned FifoCntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StCapture,
    StRelease,
    StWaitSpace,
    StDone
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cyc_cnt_q;
  logic [7:0]        rem_q;
  logic [7:0]        cur_index_q;
  logic              busy_q;
  logic              done_q;
  logic              hs_q;
  logic [7:0]        core_index_q;

  logic [7:0]        mem_data_q  [FIFO_DEPTH];
  logic [7:0]        mem_index_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [FifoCntW-1:0] fifo_cnt_q;

  logic fifo_full;
  logic push;
  logic pop;
  logic abort_act;
  logic abortable;

`ifdef SWEEP_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  assign fifo_full = (fifo_cnt_q == FifoCntW'(FIFO_DEPTH));
  assign abortable = (state_q == StLaunch) || (state_q == StCapture) ||
                     (state_q == StRelease) || (state_q == StWaitSpace);
  // An abort landing on the capture cycle drops that sample.
  assign push      = (state_q == StCapture) && !abort_act && !fifo_full;
  assign pop       = (fifo_cnt_q != '0) && res_ready;

  // Sweep sequencer; all visible control outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cyc_cnt_q    <= '0;
      rem_q        <= 8'd0;
      cur_index_q  <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hs_q         <= 1'b0;
      core_index_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      if (abort_act && abortable) begin
        // Finish through RELEASE so the core still gets a full low gap.
        state_q   <= StRelease;
        rem_q     <= 8'd0;
        hs_q      <= 1'b0;
        cyc_cnt_q <= CntW'(GAP_CYCLES - 1);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              busy_q      <= 1'b1;
              rem_q       <= count;
              cur_index_q <= first_index;
              if (count != 8'd0) begin
                state_q      <= StLaunch;
                hs_q         <= 1'b1;
                core_index_q <= first_index;
                cyc_cnt_q    <= CntW'(RUN_CYCLES - 1);
              end else begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end
          StLaunch: begin
            if (cyc_cnt_q == '0) begin
              state_q <= StCapture;
              hs_q    <= 1'b0;
            end else begin
              cyc_cnt_q <= cyc_cnt_q - CntW'(1);
            end
          end
          StCapture: begin
            rem_q       <= rem_q - 8'd1;
            cur_index_q <= cur_index_q + 8'd1;
            cyc_cnt_q   <= CntW'(GAP_CYCLES - 1);
            state_q     <= StRelease;
          end
          StRelease: begin
            if (cyc_cnt_q != '0) begin
              cyc_cnt_q <= cyc_cnt_q - CntW'(1);
            end else if (rem_q == 8'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (fifo_full) begin
              state_q <= StWaitSpace;
            end else begin
              state_q      <= StLaunch;
              hs_q         <= 1'b1;
              core_index_q <= cur_index_q;
              cyc_cnt_q    <= CntW'(RUN_CYCLES - 1);
            end
          end
          StWaitSpace: begin
            if (!fifo_full) begin
              state_q      <= StLaunch;
              hs_q         <= 1'b1;
              core_index_q <= cur_index_q;
              cyc_cnt_q    <= CntW'(RUN_CYCLES - 1);
            end
          end
          StDone: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            hs_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Result FIFO; contents persist across sweeps and clear only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data_q[i]  <= 8'd0;
        mem_index_q[i] <= 8'd0;
      end
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q]  <= core_result;
        mem_index_q[wr_ptr_q] <= cur_index_q;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + FifoCntW'(1);
      end else if (!push && pop) begin
        fifo_cnt_q <= fifo_cnt_q - FifoCntW'(1);
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign core_handshake = hs_q;
  assign core_index     = core_index_q;
  assign res_valid      = (fifo_cnt_q != '0);
  assign res_data       = mem_data_q[rd_ptr_q];
  assign res_index      = mem_index_q[rd_ptr_q];

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: randomized scenarios for sweep_ctrl against a core model
// (result = index + 3) and an index-range reference model.
module tb_sweep_ctrl;

  localparam int unsigned RunCycles = 8;
  localparam int unsigned GapCycles = 2;
  localparam int unsigned Depth     = 4;
  localparam int          Period    = RunCycles + 1 + GapCycles;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] first_index = 8'd0;
  logic [7:0] count = 8'd0;
  logic       busy, done, core_handshake, res_valid;
  logic [7:0] core_index, core_result, res_data, res_index;
  logic       res_ready = 1'b0;
`ifdef SWEEP_ABORT_EN
  logic       abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit   mon_en = 1'b0;
  bit   busy_exp = 1'b0;
  bit   hs_prev = 1'b0;
  bit   rand_ready = 1'b0;
  int   hs_run = 0;
  int   busy_err = 0;
  int   hs_starts[$];
  int   hs_lens[$];
  int   done_cycles[$];
  logic [7:0] obs_data[$];
  logic [7:0] obs_tag[$];
  logic [7:0] exp_data[$];
  logic [7:0] exp_tag[$];

  sweep_ctrl #(
    .RUN_CYCLES(RunCycles),
    .GAP_CYCLES(GapCycles),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .first_index   (first_index),
    .count         (count),
`ifdef SWEEP_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .done          (done),
    .core_handshake(core_handshake),
    .core_index    (core_index),
    .core_result   (core_result),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_index     (res_index),
    .res_ready     (res_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: result follows index + 3 while handshake is high, else holds.
  always @(posedge clk) begin
    if (reset) core_result <= 8'h00;
    else if (core_handshake) core_result <= core_index + 8'd3;
  end

  // Passive observer sampling on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (core_handshake === 1'b1) begin
          if (!hs_prev) hs_starts.push_back(cyc);
          hs_run++;
          hs_prev = 1'b1;
        end else if (hs_prev) begin
          hs_lens.push_back(hs_run);
          hs_run  = 0;
          hs_prev = 1'b0;
        end
        if (done === 1'b1) done_cycles.push_back(cyc);
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
          obs_data.push_back(res_data);
          obs_tag.push_back(res_index);
        end
        if (busy !== busy_exp) busy_err++;
        if (done === 1'b1) busy_exp = 1'b0;
      end
    end
  endtask

  task automatic clear_mon();
    hs_starts.delete();
    hs_lens.delete();
    done_cycles.delete();
    obs_data.delete();
    obs_tag.delete();
    exp_data.delete();
    exp_tag.delete();
    hs_run   = 0;
    hs_prev  = 1'b0;
    busy_err = 0;
    busy_exp = 1'b0;
  endtask

  // Reference: a sweep of n samples from fi yields tags fi..fi+n-1 (mod 256).
  task automatic model_sweep(input logic [7:0] fi, input int n);
    for (int i = 0; i < n; i++) begin
      exp_tag.push_back(8'(int'(fi) + i));
      exp_data.push_back(8'(int'(fi) + i + 3));
    end
  endtask

  task automatic start_sweep(input logic [7:0] fi, input logic [7:0] n, output int s);
    @(posedge clk); #1;
    first_index = fi;
    count       = n;
    start       = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    s        = cyc;
    busy_exp = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
      if (done_cycles.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit ok);
    rand_ready = 1'b0;
    res_ready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!res_valid && i >= 2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_launches(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 * Period; i++) begin
      @(posedge clk); #1;
      if (hs_starts.size() >= k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, core_handshake, core_index, res_valid, res_data, res_index} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b hs=%b idx=%h v=%b d=%h t=%h want all 0",
               busy, done, core_handshake, core_index, res_valid, res_data, res_index);
    if ({busy, done, core_handshake, core_index, res_valid, res_data, res_index} !== '0)
      errors++;
    reset = 1'b0;
  endtask

  task automatic test_basic_sweep();
    int s;
    bit ok1, ok2;
    clear_mon();
    mon_en = 1'b1;
    res_ready = 1'b1;
    model_sweep(8'h10, 3);
    start_sweep(8'h10, 8'd3, s);
    wait_done(10 * Period, ok1);
    drain(ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL basic_finish got %b%b want 11", ok1, ok2); end
    checks++;
    if (obs_tag.size() != 3) begin
      errors++; $display("FAIL basic_count got %0d want 3", obs_tag.size());
    end
    for (int i = 0; i < obs_tag.size() && i < 3; i++) begin
      checks++;
      if (obs_tag[i] !== exp_tag[i] || obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL basic_result[%0d] got %h/%h want %h/%h", i, obs_tag[i], obs_data[i],
                 exp_tag[i], exp_data[i]);
      end
    end
    checks++;
    if (hs_starts.size() != 3) begin
      errors++; $display("FAIL basic_launches got %0d want 3", hs_starts.size());
    end
    for (int i = 0; i < hs_starts.size() && i < 3; i++) begin
      checks++;
      if (hs_starts[i] != s + i * Period || hs_lens.size() <= i || hs_lens[i] != RunCycles) begin
        errors++;
        $display("FAIL basic_hs[%0d] got start=%0d len=%0d want start=%0d len=%0d", i,
                 hs_starts[i] - s, (hs_lens.size() > i) ? hs_lens[i] : -1, i * Period, RunCycles);
      end
    end
    checks++;
    if (done_cycles.size() != 1 || done_cycles[0] != s + 3 * Period) begin
      errors++;
      $display("FAIL basic_done got n=%0d at=%0d want n=1 at=%0d", done_cycles.size(),
               (done_cycles.size() > 0) ? done_cycles[0] - s : -1, 3 * Period);
    end
    checks++;
    if (busy_err != 0) begin errors++; $display("FAIL basic_busy got %0d bad cycles want 0", busy_err); end
    mon_en = 1'b0;
  endtask

  task automatic test_wrap();
    int s;
    bit ok1, ok2;
    clear_mon();
    mon_en = 1'b1;
    model_sweep(8'hFE, 3);
    start_sweep(8'hFE, 8'd3, s);
    wait_done(10 * Period, ok1);
    drain(ok2);
    checks++;
    if (obs_tag.size() != 3 || !ok1 || !ok2) begin
      errors++; $display("FAIL wrap_count got %0d want 3", obs_tag.size());
    end
    for (int i = 0; i < obs_tag.size() && i < 3; i++) begin
      checks++;
      if (obs_tag[i] !== exp_tag[i] || obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap_result[%0d] got %h/%h want %h/%h", i, obs_tag[i], obs_data[i],
                 exp_tag[i], exp_data[i]);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic test_zero_count();
    int s;
    bit ok;
    clear_mon();
    mon_en = 1'b1;
    start_sweep(8'h55, 8'd0, s);
    wait_done(10, ok);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cycles.size() != 1 || done_cycles[0] != s) begin
      errors++;
      $display("FAIL zero_done got n=%0d at=%0d want n=1 at=0", done_cycles.size(),
               (done_cycles.size() > 0) ? done_cycles[0] - s : -1);
    end
    checks++;
    if (hs_starts.size() != 0) begin errors++; $display("FAIL zero_hs got %0d want 0", hs_starts.size()); end
    checks++;
    if (busy_err != 0) begin errors++; $display("FAIL zero_busy got %0d want 0", busy_err); end
    mon_en = 1'b0;
  endtask

  task automatic test_start_ignored();
    int s;
    bit ok1, ok2, ok3;
    clear_mon();
    mon_en = 1'b1;
    model_sweep(8'h40, 3);
    start_sweep(8'h40, 8'd3, s);
    wait_launches(2, ok1);
    first_index = 8'h80;
    count       = 8'd5;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10 * Period, ok2);
    drain(ok3);
    checks++;
    if (obs_tag.size() != 3 || hs_starts.size() != 3 || done_cycles.size() != 1) begin
      errors++;
      $display("FAIL ignore_start got res=%0d launches=%0d dones=%0d want 3/3/1",
               obs_tag.size(), hs_starts.size(), done_cycles.size());
    end
    for (int i = 0; i < obs_tag.size() && i < 3; i++) begin
      checks++;
      if (obs_tag[i] !== exp_tag[i] || obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL ignore_result[%0d] got %h/%h want %h/%h", i, obs_tag[i], obs_data[i],
                 exp_tag[i], exp_data[i]);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int s;
    bit ok1, ok2;
    clear_mon();
    mon_en = 1'b1;
    res_ready = 1'b0;
    model_sweep(8'h20, 6);
    start_sweep(8'h20, 8'd6, s);
    repeat (4 * Period + 20) @(posedge clk);
    #1;
    checks++;
    if (hs_starts.size() != 4 || core_handshake !== 1'b0 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got launches=%0d hs=%b valid=%b want 4/0/1",
               hs_starts.size(), core_handshake, res_valid);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    repeat (3 * Period) @(posedge clk);
    #1;
    checks++;
    if (hs_starts.size() != 5 || core_handshake !== 1'b0) begin
      errors++;
      $display("FAIL bp_one_more got launches=%0d hs=%b want 5/0", hs_starts.size(), core_handshake);
    end
    res_ready = 1'b1;
    wait_done(10 * Period, ok1);
    drain(ok2);
    checks++;
    if (obs_tag.size() != 6 || !ok1 || !ok2) begin
      errors++; $display("FAIL bp_count got %0d want 6", obs_tag.size());
    end
    for (int i = 0; i < obs_tag.size() && i < 6; i++) begin
      checks++;
      if (obs_tag[i] !== exp_tag[i] || obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL bp_result[%0d] got %h/%h want %h/%h", i, obs_tag[i], obs_data[i],
                 exp_tag[i], exp_data[i]);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic test_random_sweeps();
    int s, n;
    bit ok1, ok2;
    logic [7:0] fi;
    for (int it = 0; it < 5; it++) begin
      clear_mon();
      mon_en = 1'b1;
      fi = 8'($urandom_range(0, 255));
      n  = int'($urandom_range(1, 7));
      model_sweep(fi, n);
      rand_ready = 1'b1;
      start_sweep(fi, 8'(n), s);
      wait_done(40 * Period, ok1);
      drain(ok2);
      checks++;
      if (obs_tag.size() != n || done_cycles.size() != 1 || !ok1 || !ok2) begin
        errors++;
        $display("FAIL rand%0d_count got res=%0d dones=%0d want %0d/1", it, obs_tag.size(),
                 done_cycles.size(), n);
      end
      for (int i = 0; i < obs_tag.size() && i < n; i++) begin
        checks++;
        if (obs_tag[i] !== exp_tag[i] || obs_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL rand%0d_result[%0d] got %h/%h want %h/%h", it, i, obs_tag[i],
                   obs_data[i], exp_tag[i], exp_data[i]);
        end
      end
      checks++;
      if (hs_lens.size() != n || hs_lens.min() != '{RunCycles} || hs_lens.max() != '{RunCycles}
          || busy_err != 0) begin
        errors++;
        $display("FAIL rand%0d_timing got segments=%0d busy_err=%0d want %0d x %0d, 0", it,
                 hs_lens.size(), busy_err, n, RunCycles);
      end
      mon_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int s;
    bit ok1, ok2, ok3;
    logic [7:0] fi;
    clear_mon();
    mon_en = 1'b1;
    fi = 8'($urandom_range(0, 255));
    start_sweep(fi, 8'd4, s);
    wait_launches(2, ok1);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!ok1 || {busy, done, core_handshake, core_index, res_valid, res_data, res_index} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b hs=%b idx=%h v=%b d=%h t=%h want all 0",
               busy, core_handshake, core_index, res_valid, res_data, res_index);
    end
    reset = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    fi = 8'($urandom_range(0, 255));
    model_sweep(fi, 2);
    start_sweep(fi, 8'd2, s);
    wait_done(10 * Period, ok2);
    drain(ok3);
    checks++;
    if (obs_tag.size() != 2 || !ok2 || !ok3 || done_cycles.size() != 1 ||
        done_cycles[0] != s + 2 * Period) begin
      errors++;
      $display("FAIL midreset_resweep got res=%0d dones=%0d want 2/1", obs_tag.size(),
               done_cycles.size());
    end
    for (int i = 0; i < obs_tag.size() && i < 2; i++) begin
      checks++;
      if (obs_tag[i] !== exp_tag[i] || obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL midreset_result[%0d] got %h/%h want %h/%h", i, obs_tag[i], obs_data[i],
                 exp_tag[i], exp_data[i]);
      end
    end
    mon_en = 1'b0;
  endtask

`ifdef SWEEP_ABORT_EN
  task automatic test_abort();
    int s, ce;
    bit ok1, ok2, ok3;
    logic hs_now;
    clear_mon();
    mon_en = 1'b1;
    res_ready = 1'b1;
    start_sweep(8'h30, 8'd5, s);
    wait_launches(2, ok1);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort  = 1'b0;
    ce     = cyc;
    hs_now = core_handshake;
    wait_done(10 * Period, ok2);
    drain(ok3);
    checks++;
    if (hs_now !== 1'b0 || !ok1 || !ok2) begin
      errors++; $display("FAIL abort_hs got %b want 0", hs_now);
    end
    checks++;
    if (done_cycles.size() != 1 || done_cycles[0] != ce + GapCycles) begin
      errors++;
      $display("FAIL abort_done got n=%0d at=%0d want n=1 at=%0d", done_cycles.size(),
               (done_cycles.size() > 0) ? done_cycles[0] - ce : -1, GapCycles);
    end
    checks++;
    if (obs_tag.size() != 1 || obs_tag[0] !== 8'h30 || obs_data[0] !== 8'h33) begin
      errors++; $display("FAIL abort_results got n=%0d want 1 (30/33)", obs_tag.size());
    end
    mon_en = 1'b0;
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic_sweep();
    test_wrap();
    test_zero_count();
    test_start_ignored();
    test_backpressure();
    test_random_sweeps();
    test_reset_mid_sweep();
`ifdef SWEEP_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Sequencer that drives the picoMIPS core's `handshake`/`index` pair across a programmed range of waveform sample indices and collects the 8-bit `result` values into a small output FIFO. The core has no completion flag, so each sample runs for a fixed cycle budget. The block then captures `result`, releases `handshake` so the core returns to IDLE, and launches the next index. It sits between the system-level host (start/valid-ready result stream) and one `cpu` instance.

## Interface

- `RUN_CYCLES`, 96: cycles `core_handshake` is held high per sample; must cover full program execution to HALT.
- `GAP_CYCLES`, 2: cycles `core_handshake` is held low between samples; minimum 2.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, minimum 2.

Ports:

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin sweep; sampled only in IDLE.
- `first_index` in 8: first sample index; captured on accepted `start`.
- `count` in 8: number of samples; captured on accepted `start`; 0 means none.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse at sweep end.
- `core_handshake` out 1: to `cpu.handshake`.
- `core_index` out 8: to `cpu.index`.
- `core_result` in 8: from `cpu.result`.
- `res_valid` out 1: FIFO head valid.
- `res_data` out 8: FIFO head result.
- `res_index` out 8: index that produced `res_data`.
- `res_ready` in 1: consumer pops the head when `res_valid && res_ready`.

## Operation

- States: IDLE, LAUNCH, CAPTURE, RELEASE, WAIT_SPACE, DONE.
- Reset: state IDLE, FIFO flushed; all outputs 0 (`busy`, `done`, `core_handshake`, `core_index`, `res_valid`, `res_data`, `res_index`).
- IDLE:
  - `start` with `count != 0` goes to LAUNCH.
  - `start` with `count == 0` goes to DONE.
  - `start` while not in IDLE is ignored.
- LAUNCH:
  - `core_handshake` = 1 and `core_index` = current index.
  - Runs for RUN_CYCLES cycles, counted down by a cycle counter, then goes to CAPTURE.
- CAPTURE (1 cycle):
  - `core_handshake` = 0.
  - Pushes {`core_result`, current index} into the FIFO.
  - Decrements the remaining count and increments the index modulo 256 (0xFF+1 wraps to 0x00).
  - Goes to RELEASE.
- RELEASE: `core_handshake` = 0 for GAP_CYCLES cycles. Then:
  - remaining == 0: go to DONE;
  - FIFO full: go to WAIT_SPACE;
  - otherwise: go to LAUNCH.
- WAIT_SPACE: `core_handshake` stays 0; go to LAUNCH on the first cycle the FIFO is not full.
- DONE: `done` = 1 for one cycle, then IDLE.
- `core_index` holds its last value outside LAUNCH.
- FIFO rules:
  - Push occurs only when not full; this is guaranteed by the WAIT_SPACE check, so CAPTURE never overflows.
  - Simultaneous push and pop leaves the occupancy unchanged.
  - Pop when empty is ignored.
  - FIFO contents survive DONE and IDLE and are cleared only by `reset`.
- Reset mid-sweep: immediate return to reset values on the next edge. `core_handshake` drops, which lets the core leave HALT.

## Timing

- Accepted `start` at edge N: from N+1, `busy` = 1, `core_handshake` = 1, `core_index` = `first_index`.
- `core_handshake` is high for exactly RUN_CYCLES consecutive cycles per sample.
- `core_result` is sampled at the CAPTURE edge; `res_valid` rises the following cycle if the FIFO was empty.
- Unstalled sample period = RUN_CYCLES + 1 + GAP_CYCLES.
- `done` comes 1 cycle after the last RELEASE; `busy` falls on the cycle after `done`.
- Zero-count sweep: `done` at N+1; `core_handshake` never rises.

## Configuration

- `SWEEP_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort` in LAUNCH, CAPTURE, RELEASE or WAIT_SPACE forces RELEASE on the next edge with remaining = 0.
  - The sweep ends via DONE; no further pushes occur.
  - An `abort` on a CAPTURE cycle suppresses that push.
  - In IDLE/DONE `abort` is ignored.
- Undefined: no `abort` port; sweeps always run to completion.

## Test plan

Settings: RUN_CYCLES=8, GAP_CYCLES=2, FIFO_DEPTH=4, with a core model whose `result` = `index`+3 while handshake is high.

- Basic sweep: `start`, `first_index`=0x10, `count`=3 with `res_ready`=1 → results {0x13,0x14,0x15}, tagged 0x10–0x12. Handshake high 8 cycles per sample, period 11 cycles, single `done`.
- Backpressure: `count`=6 with `res_ready`=0 → 4 pushes, then `core_handshake` stays 0 in WAIT_SPACE. Raising `res_ready` for 1 cycle → exactly one more sample launches.
- Wrap: `first_index`=0xFE, `count`=3 → tags 0xFE, 0xFF, 0x00.
- Edge starts:
  - `count`=0 → `done` one cycle after `start`, no handshake.
  - `start` pulsed mid-sweep → ignored.
- Reset mid-sweep: assert `reset` during LAUNCH of the 2nd sample → next cycle all outputs 0, `res_valid`=0, then a new sweep runs normally.
- With `SWEEP_ABORT_EN`: `count`=5 with `abort` in the 2nd LAUNCH → exactly 1 result, `core_handshake` low next edge, `done` after GAP_CYCLES+1.
